// File: rtl/accel_quant_pkg.sv
// rtl/accel_quant_pkg.sv - shared requant types, bounds and drain FSM states
package accel_quant_pkg;

   localparam int MULT_W  = 16;
   localparam int SHIFT_W = 5;
   localparam int OUT_W   = 8;

   localparam int Q_MAX = (1 << (OUT_W - 1)) - 1;
   localparam int Q_MIN = -(1 << (OUT_W - 1));

   typedef logic signed [OUT_W-1:0] q8_t;

   typedef struct packed {
      logic signed [MULT_W-1:0] mult;
      logic [SHIFT_W-1:0]       shift;
      q8_t                      zp;
   } requant_cfg_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      FLUSH
   } drain_state_e;

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - combinational single-element requant to int8; QUANT_RELU_EN adds a clamp at zp
module requant_lane
   import accel_quant_pkg::*;
#(
   parameter int ACC_WIDTH  = 32,
   parameter int MULT_WIDTH = 16
) (
   input  logic signed [ACC_WIDTH-1:0]  acc_i,
   input  logic signed [MULT_WIDTH-1:0] mult_i,
   input  logic        [SHIFT_W-1:0]    shift_i,
   input  q8_t                          zp_i,
   output q8_t                          q_o,
   output logic                         sat_o
);

   // One guard bit so the rounding add can never wrap the full product.
   localparam int PW = ACC_WIDTH + MULT_WIDTH + 1;
   localparam logic signed [PW-1:0] HI = PW'(Q_MAX);
   localparam logic signed [PW-1:0] LO = PW'(Q_MIN);

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] rnd;
   logic signed [PW-1:0] shifted;
   logic signed [PW-1:0] biased;
   logic signed [PW-1:0] clip_in;

   always_comb begin
      prod = PW'(acc_i) * PW'(mult_i);
      rnd  = '0;
      if (shift_i != '0) begin
         rnd = PW'(1) << (shift_i - 1'b1);
      end
      shifted = (prod + rnd) >>> shift_i;
      biased  = shifted + PW'(zp_i);
      clip_in = biased;
`ifdef QUANT_RELU_EN
      if (biased < PW'(zp_i)) begin
         clip_in = PW'(zp_i);
      end
`endif
      sat_o = 1'b0;
      q_o   = clip_in[OUT_W-1:0];
      if (clip_in > HI) begin
         q_o   = HI[OUT_W-1:0];
         sat_o = 1'b1;
      end else if (clip_in < LO) begin
         q_o   = LO[OUT_W-1:0];
         sat_o = 1'b1;
      end
   end

endmodule

// File: rtl/accumulator_requant_drain.sv
// rtl/accumulator_requant_drain.sv - snapshots the accumulator tile and drains requantized rows
module accumulator_requant_drain
   import accel_quant_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int MULT_WIDTH = 16,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic                                     start,
   input  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] acc_in,
   input  logic                                     acc_overflow_in,
   input  logic [MULT_WIDTH-1:0]                    quant_mult,
   input  logic [4:0]                               quant_shift,
   input  logic [OUT_WIDTH-1:0]                     quant_zp,
   output logic                                     acc_clear,
   output logic                                     busy,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [COLS-1:0][OUT_WIDTH-1:0]           out_data,
   output logic [$clog2(ROWS)-1:0]                  out_row,
   output logic                                     out_last,
   output logic                                     sat_flag,
   output logic                                     done
);

   localparam int RW = $clog2(ROWS);

   drain_state_e                             state_q, state_d;
   logic [RW-1:0]                            row_q, row_d;
   logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
   requant_cfg_t                             cfg_q, cfg_d;
   logic                                     valid_q, valid_d;
   logic [COLS-1:0][OUT_WIDTH-1:0]           data_q, data_d;
   logic [RW-1:0]                            orow_q, orow_d;
   logic                                     last_q, last_d;
   logic                                     sat_q, sat_d;
   logic                                     done_q, done_d;
   logic                                     clear_q, clear_d;

   logic [COLS-1:0][OUT_W-1:0]               lane_q;
   logic [COLS-1:0]                          lane_sat;

   for (genvar c = 0; c < COLS; c++) begin : g_lane
      requant_lane #(
         .ACC_WIDTH (ACC_WIDTH),
         .MULT_WIDTH(MULT_WIDTH)
      ) u_lane (
         .acc_i  (acc_q[row_q][c]),
         .mult_i (cfg_q.mult),
         .shift_i(cfg_q.shift),
         .zp_i   (cfg_q.zp),
         .q_o    (lane_q[c]),
         .sat_o  (lane_sat[c])
      );
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      acc_d   = acc_q;
      cfg_d   = cfg_q;
      valid_d = valid_q;
      data_d  = data_q;
      orow_d  = orow_q;
      last_d  = last_q;
      sat_d   = sat_q;
      done_d  = 1'b0;
      clear_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = acc_in;
               cfg_d   = '{mult: quant_mult, shift: quant_shift, zp: quant_zp};
               sat_d   = acc_overflow_in;
               row_d   = '0;
               clear_d = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Output register refills whenever it is empty or being accepted.
            if (!valid_q || out_ready) begin
               valid_d = 1'b1;
               data_d  = lane_q;
               orow_d  = row_q;
               last_d  = (row_q == RW'(ROWS - 1));
               sat_d   = sat_q | (|lane_sat);
               row_d   = row_q + RW'(1);
               if (row_q == RW'(ROWS - 1)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (out_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         acc_q   <= '0;
         cfg_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         orow_q  <= '0;
         last_q  <= 1'b0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         acc_q   <= acc_d;
         cfg_q   <= cfg_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         orow_q  <= orow_d;
         last_q  <= last_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
         clear_q <= clear_d;
      end
   end

   assign acc_clear = clear_q;
   assign busy      = (state_q != IDLE);
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_row   = orow_q;
   assign out_last  = last_q;
   assign sat_flag  = sat_q;
   assign done      = done_q;

endmodule

// File: tb/tb_accumulator_requant_drain.sv
// tb/tb_accumulator_requant_drain.sv - self-checking bench for accumulator_requant_drain
module tb_accumulator_requant_drain;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int AW   = 32;
   localparam int MW   = 16;
   localparam int OW   = 8;

   typedef logic [ROWS-1:0][COLS-1:0][AW-1:0] mat_t;
   typedef logic [ROWS-1:0][COLS-1:0][OW-1:0] rows_t;

   typedef struct {
      int acc;
      int mult;
      int shift;
      int zp;
      int q;
      bit sat;
      int q_relu;
      bit sat_relu;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic                   start;
   mat_t                   acc_in;
   logic                   acc_overflow_in;
   logic [MW-1:0]          quant_mult;
   logic [4:0]             quant_shift;
   logic [OW-1:0]          quant_zp;
   logic                   acc_clear;
   logic                   busy;
   logic                   out_valid;
   logic                   out_ready;
   logic [COLS-1:0][OW-1:0] out_data;
   logic [1:0]             out_row;
   logic                   out_last;
   logic                   sat_flag;
   logic                   done;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   accumulator_requant_drain #(
      .ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(AW), .MULT_WIDTH(MW), .OUT_WIDTH(OW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .acc_in         (acc_in),
      .acc_overflow_in(acc_overflow_in),
      .quant_mult     (quant_mult),
      .quant_shift    (quant_shift),
      .quant_zp       (quant_zp),
      .acc_clear      (acc_clear),
      .busy           (busy),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_row        (out_row),
      .out_last       (out_last),
      .sat_flag       (sat_flag),
      .done           (done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference requant: exact integer arithmetic, floor shift after half-up bias.
   function automatic logic [8:0] ref_q(input longint acc, input longint mult,
                                        input int shift, input longint zp);
      longint v;
      v = acc * mult;
      if (shift > 0) v = v + (longint'(1) << (shift - 1));
      v = v >>> shift;
      v = v + zp;
`ifdef QUANT_RELU_EN
      if (v < zp) v = zp;
`endif
      if (v > 127) return {1'b1, 8'h7f};
      if (v < -128) return {1'b1, 8'h80};
      return {1'b0, v[7:0]};
   endfunction

   task automatic run_tile(input string tag, input mat_t mat, input int mult, input int shift,
                           input int zp, input bit ovf, input rows_t erows, input bit esat,
                           input int mode, input bit repulse);
      int beats, cyc, clears;
      bit held;
      logic [COLS-1:0][OW-1:0] hd;
      logic [1:0] hr;
      logic hl;
      acc_in          = mat;
      acc_overflow_in = ovf;
      quant_mult      = MW'(mult);
      quant_shift     = 5'(shift);
      quant_zp        = OW'(zp);
      out_ready       = 1'b1;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " acc_clear"}, 64'(acc_clear), 64'd1);
      chk({tag, " busy"}, 64'(busy), 64'd1);
      chk({tag, " sat_init"}, 64'(sat_flag), 64'(ovf));
      chk({tag, " done_low"}, 64'(done), 64'd0);
      chk({tag, " valid_low"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      beats = 0; cyc = 0; clears = 0; held = 1'b0;
      hd = '0; hr = '0; hl = 1'b0;
      while (beats < ROWS && cyc < 200) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (repulse) begin
            start = (cyc == 1);
            if (cyc == 1) acc_in = ~mat;
         end
         if (acc_clear) clears++;
         if (out_valid) begin
            if (held) begin
               chk({tag, " hold_data"}, 64'(out_data), 64'(hd));
               chk({tag, " hold_row"}, 64'(out_row), 64'(hr));
               chk({tag, " hold_last"}, 64'(out_last), 64'(hl));
            end
            if (out_ready) begin
               chk($sformatf("%s row%0d idx", tag, beats), 64'(out_row), 64'(beats));
               chk($sformatf("%s row%0d data", tag, beats), 64'(out_data), 64'(erows[beats]));
               chk($sformatf("%s row%0d last", tag, beats), 64'(out_last), 64'(beats == ROWS - 1));
               beats++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               hd = out_data; hr = out_row; hl = out_last;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, " beats"}, 64'(beats), 64'(ROWS));
      if (mode == 0) chk({tag, " throughput"}, 64'(cyc), 64'(ROWS));
      chk({tag, " extra_clear"}, 64'(clears), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd1);
      chk({tag, " busy_drop"}, 64'(busy), 64'd0);
      chk({tag, " valid_drop"}, 64'(out_valid), 64'd0);
      chk({tag, " sat_flag"}, 64'(sat_flag), 64'(esat));
   endtask

   vec_t  tbl[14];
   mat_t  mat;
   rows_t erows;

   initial begin
      tbl[0]  = '{5, 1, 1, 0, 3, 0, 3, 0};
      tbl[1]  = '{-5, 1, 1, 0, -2, 0, 0, 0};
      tbl[2]  = '{4, 1, 1, 0, 2, 0, 2, 0};
      tbl[3]  = '{1000, 1, 0, 0, 127, 1, 127, 1};
      tbl[4]  = '{-1000, 1, 0, 0, -128, 1, 0, 0};
      tbl[5]  = '{-50, 1, 0, 3, -47, 0, 3, 0};
      tbl[6]  = '{100, -3, 2, 10, -65, 0, 10, 0};
      tbl[7]  = '{7, 1, 0, -128, -121, 0, -121, 0};
      tbl[8]  = '{2147483647, 32767, 31, 0, 127, 1, 127, 1};
      tbl[9]  = '{int'(32'h8000_0000), -32768, 31, 0, 127, 1, 127, 1};
      tbl[10] = '{3, 1, 1, 0, 2, 0, 2, 0};
      tbl[11] = '{-3, 1, 1, 0, -1, 0, 0, 0};
      tbl[12] = '{200, 1, 0, -100, 100, 0, 100, 0};
      tbl[13] = '{-200, 1, 0, 100, -100, 0, 100, 0};

      reset_n = 1'b0; start = 1'b0; acc_in = '0; acc_overflow_in = 1'b0;
      quant_mult = '0; quant_shift = '0; quant_zp = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset acc_clear", 64'(acc_clear), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_last", 64'(out_last), 64'd0);
      chk("reset sat_flag", 64'(sat_flag), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset out_data", 64'(out_data), 64'd0);
      chk("reset out_row", 64'(out_row), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            mat[r][c]   = AW'(r * 4 + c);
            erows[r][c] = OW'(r * 4 + c);
         end
      run_tile("ramp", mat, 1, 0, 0, 1'b0, erows, 1'b0, 0, 1'b0);

      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) erows[r][c] = OW'(r * 4 + c - 5);
      run_tile("stall", mat, 1, 0, -5, 1'b0, erows, 1'b0, 1, 1'b0);

      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            mat[r][c]   = AW'(r * 4 + c + 20);
            erows[r][c] = OW'(2 * (r * 4 + c + 20));
         end
      run_tile("repulse", mat, 2, 0, 0, 1'b0, erows, 1'b0, 1, 1'b1);

      for (int i = 0; i < 14; i++) begin
         int eq;
         bit es;
`ifdef QUANT_RELU_EN
         eq = tbl[i].q_relu; es = tbl[i].sat_relu;
`else
         eq = tbl[i].q;      es = tbl[i].sat;
`endif
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               mat[r][c]   = AW'(tbl[i].acc);
               erows[r][c] = OW'(eq);
            end
         run_tile($sformatf("vec%0d", i), mat, tbl[i].mult, tbl[i].shift, tbl[i].zp,
                  1'b0, erows, es, i % 3, 1'b0);
      end

      for (int t = 0; t < 8; t++) begin
         int mult, shift, zp, v;
         bit ovf, es;
         logic [8:0] r9;
         mult  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 65535)) - 32768
                                             : int'($urandom_range(0, 8)) - 4;
         shift = int'($urandom_range(0, 31));
         zp    = int'($urandom_range(0, 255)) - 128;
         ovf   = 1'($urandom_range(0, 1));
         es    = ovf;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               case ($urandom_range(0, 2))
                  0:       v = int'($urandom_range(0, 400)) - 200;
                  1:       v = int'($urandom);
                  default: v = int'($urandom_range(0, 200000)) - 100000;
               endcase
               mat[r][c]   = AW'(v);
               r9          = ref_q(longint'(v), longint'(mult), shift, longint'(zp));
               erows[r][c] = r9[7:0];
               es          = es | r9[8];
            end
         run_tile($sformatf("rand%0d", t), mat, mult, shift, zp, ovf, erows, es,
                  int'($urandom_range(0, 2)), 1'b0);
      end

      begin
         bit seen_done;
         acc_in = '1; acc_overflow_in = 1'b1; quant_mult = 16'd1;
         quant_shift = '0; quant_zp = '0; out_ready = 1'b0; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         chk("midreset valid_before", 64'(out_valid), 64'd1);
         chk("midreset sat_before", 64'(sat_flag), 64'd1);
         reset_n = 1'b0;
         @(negedge clk);
         chk("midreset out_valid", 64'(out_valid), 64'd0);
         chk("midreset busy", 64'(busy), 64'd0);
         chk("midreset sat_flag", 64'(sat_flag), 64'd0);
         reset_n = 1'b1;
         out_ready = 1'b1;
         seen_done = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
         end
         chk("midreset no_done", 64'(seen_done), 64'd0);
         chk("midreset idle", 64'(busy), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/accumulator_requant_drain.md
# accumulator_requant_drain

Downstream of the accumulator bank. On a `start` pulse it snapshots the full ROWS×COLS accumulator matrix and the bank's overflow flag, then issues a one-cycle clear back to the bank. It requantizes each 32-bit sum to int8 (fixed-point multiply, rounding right shift, zero-point add, saturation) and streams the results out one row per beat over a valid/ready handshake. Snapshotting lets the bank start the next tile while this block drains.

## Interface
Parameters:
- `ROWS`, 4: matrix rows; one output beat per row.
- `COLS`, 4: matrix columns; elements per beat.
- `ACC_WIDTH`, 32: accumulator element width, signed.
- `MULT_WIDTH`, 16: requant multiplier width, signed.
- `OUT_WIDTH`, 8: output element width, signed.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse: snapshot the matrix and begin draining. Ignored unless IDLE.
- `acc_in`  in  ACC_WIDTH × [ROWS][COLS]  signed accumulated sums from the bank.
- `acc_overflow_in`  in  1  bank overflow flag, sampled with the snapshot.
- `quant_mult`  in  MULT_WIDTH  signed multiplier, sampled at start.
- `quant_shift`  in  5  right-shift amount 0..31, sampled at start.
- `quant_zp`  in  OUT_WIDTH  signed zero point, sampled at start.
- `acc_clear`  out  1  one-cycle clear pulse to the bank.
- `busy`  out  1  high in any state except IDLE.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  OUT_WIDTH × [COLS]  one requantized row.
- `out_row`  out  $clog2(ROWS)  row index of the current beat.
- `out_last`  out  1  high on the final row's beat.
- `sat_flag`  out  1  sticky for the tile: any element saturated, or the latched bank overflow.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, DRAIN, FLUSH.
- IDLE, `start`=1:
  - latch `acc_in`, `acc_overflow_in`, `quant_mult`, `quant_shift` and `quant_zp`;
  - set `sat_flag` to the latched overflow value;
  - set the load row index to 0; go to DRAIN.
- DRAIN: the output register loads row index r when it is empty or its beat is accepted in the same cycle (`out_valid && out_ready`). Each load increments r. Loading row ROWS-1 moves the FSM to FLUSH.
- FLUSH: wait for acceptance of the last beat. Then pulse `done` and return to IDLE.
- Requant, per element:
  - p = acc × mult, signed, ACC_WIDTH+MULT_WIDTH bits, no truncation.
  - If shift > 0: p += 1 << (shift−1), round half up. Then arithmetic right shift by shift.
  - Add sign-extended zp.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - Any clamp sets `sat_flag` (sticky until the next accepted `start` or reset).
- `start` while `busy` is ignored. The snapshot is not disturbed and no `acc_clear` is issued.
- `out_data`, `out_row` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: state IDLE; `acc_clear`, `busy`, `out_valid`, `out_last`, `sat_flag` and `done` all 0; `out_data` and `out_row` 0.
- `start` sampled at edge E0:
  - `acc_clear`=1 and `busy`=1 during cycle E0→E1;
  - row 0 loads at E1, so `out_valid`=1 from E1.
- Throughput is one row per cycle with `out_ready` held high. The last beat is valid in cycle ROWS after E0.
- `done` pulses the cycle after the last acceptance. `busy` drops with it.
- A new `start` is accepted in the same cycle `done` is high. This gives ROWS+1 cycles minimum between tiles.
- `reset_n` low mid-tile: immediately return to IDLE with reset values. A partially drained tile is discarded, with no `done`.

## Configuration
- `QUANT_RELU_EN` defined: after the zp add and before saturation, values below zp clamp to zp. A ReLU clamp does not set `sat_flag`.
- Not defined: no ReLU; the full signed range passes to saturation.

## Structure
- Shared package `accel_quant_pkg` holds:
  - the `requant_cfg_t` struct (mult, shift, zp);
  - output element typedef `q8_t`;
  - FSM state enum `drain_state_e`;
  - saturation bound localparams.
- Sub-module `requant_lane`: purely combinational single-element requant, returning the result and a sat bit. It is instantiated COLS times.

## Test plan
- Reset, then mult=1, shift=0, zp=0, acc[r][c]=r*4+c → rows {0,1,2,3}…{12,13,14,15}; `out_last` on row 3; `done` one cycle after; `acc_clear` one pulse.
- acc=5, mult=1, shift=1 → 3 (round half up); acc=−5 → −2; acc=4 → 2.
- acc=1000, mult=1, shift=0, zp=0 → 127 and `sat_flag`=1; acc=−1000 → −128.
- `out_ready` toggled 1,0,0,1… → data stable while stalled; exactly ROWS beats; no duplicated or dropped rows.
- `start` re-pulsed during DRAIN with different acc_in → ignored, original data drained; `reset_n` low mid-DRAIN → `out_valid`=0 next cycle, no `done`.
- `QUANT_RELU_EN` build, acc=−50, mult=1, shift=0, zp=3 → 3 with `sat_flag`=0; without the macro → −47.
